ecc_secded_pipe: RTL and testbench

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) codec for the packet-buffer SRAM path. Extends the 128-bit SEC Hamming scheme used across the switch in three ways: configurable data width, an extra overall-parity bit for double-error detection, and registered encode and decode paths with valid/ready flow control on the decode side. Optional saturating error counters feed status logic. The encoder sits on the SRAM write port and the decoder on the read-return port.

---
 rtl/ecc_secded_pipe.sv | 158 +++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_pipe.sv
// Pipelined SECDED codec: Hamming check bits at power-of-two positions plus an overall parity bit.
// Saturating error counters are built only when ECC_ERR_CNT_EN is defined.
module ecc_secded_pipe #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16,
  localparam int R = (DATA_W <= 11)  ? 4 :
                     (DATA_W <= 26)  ? 5 :
                     (DATA_W <= 57)  ? 6 :
                     (DATA_W <= 120) ? 7 :
                     (DATA_W <= 247) ? 8 : 9,
  localparam int CODE_W = R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  input  logic [DATA_W-1:0] enc_data,
  output logic              enc_out_valid,
  output logic [DATA_W-1:0] enc_out_data,
  output logic [CODE_W-1:0] enc_out_code,
  input  logic              dec_in_valid,
  output logic              dec_in_ready,
  input  logic [DATA_W-1:0] dec_in_data,
  input  logic [CODE_W-1:0] dec_in_code,
  output logic              dec_out_valid,
  input  logic              dec_out_ready,
  output logic [DATA_W-1:0] dec_out_data,
  output logic              dec_out_sec,
  output logic              dec_out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  localparam logic [R-1:0] LAST_POS = R'(DATA_W + R);

  // Each data bit contributes its codeword position to the check bits.
  function automatic logic [R-1:0] check_bits(input logic [DATA_W-1:0] d);
    logic [R-1:0] c;
    int unsigned  p;
    c = '0;
    p = 2;
    for (int j = 0; j < DATA_W; j++) begin
      p = p + 1;
      if ((p & (p - 1)) == 0) p = p + 1;
      if (d[j]) c = c ^ p[R-1:0];
    end
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] flip_mask(input logic [R-1:0] s);
    logic [DATA_W-1:0] m;
    int unsigned       p;
    m = '0;
    p = 2;
    for (int j = 0; j < DATA_W; j++) begin
      p = p + 1;
      if ((p & (p - 1)) == 0) p = p + 1;
      m[j] = (p[R-1:0] == s);
    end
    return m;
  endfunction

  logic [R-1:0] enc_chk;
  assign enc_chk = check_bits(enc_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_out_valid <= 1'b0;
      enc_out_data  <= '0;
      enc_out_code  <= '0;
    end else begin
      enc_out_valid <= enc_valid;
      if (enc_valid) begin
        enc_out_data <= enc_data;
        enc_out_code <= {^enc_data ^ ^enc_chk, enc_chk};
      end
    end
  end

  logic              s1_valid;
  logic [R-1:0]      s1_syn;
  logic              s1_par;
  logic [DATA_W-1:0] s1_data;
  logic              s1_load;
  logic              s2_load;
  logic [R-1:0]      in_syn;

  assign s2_load      = !dec_out_valid || dec_out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign dec_in_ready = s1_load;
  assign in_syn       = check_bits(dec_in_data) ^ dec_in_code[R-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= dec_in_valid;
      if (dec_in_valid) begin
        s1_syn  <= in_syn;
        s1_par  <= ^dec_in_data ^ ^dec_in_code;
        s1_data <= dec_in_data;
      end
    end
  end

  // Odd parity with an in-range syndrome is correctable; syndromes 0 and 2^i hit no data bit.
  logic              syn_zero;
  logic              in_range;
  logic              c_sec;
  logic              c_ded;
  logic [DATA_W-1:0] fixed;

  assign syn_zero = (s1_syn == '0);
  assign in_range = (s1_syn <= LAST_POS);
  assign c_sec    = s1_par && in_range;
  assign c_ded    = s1_par ? !in_range : !syn_zero;
  assign fixed    = c_sec ? (s1_data ^ flip_mask(s1_syn)) : s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_out_valid <= 1'b0;
      dec_out_data  <= '0;
      dec_out_sec   <= 1'b0;
      dec_out_ded   <= 1'b0;
    end else if (s2_load) begin
      dec_out_valid <= s1_valid;
      if (s1_valid) begin
        dec_out_data <= fixed;
        dec_out_sec  <= c_sec;
        dec_out_ded  <= c_ded;
      end
    end
  end

`ifdef ECC_ERR_CNT_EN
  logic out_xfer;
  assign out_xfer = dec_out_valid && dec_out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (out_xfer) begin
      if (dec_out_sec && sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
      if (dec_out_ded && ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Self-checking bench for ecc_secded_pipe: directed cases plus random streams against a codeword-array model.
module tb_ecc_secded_pipe;

  localparam int DW = 128;
  localparam int CW = 4;

  function automatic int calc_r(int dw);
    int r = 0;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int R = calc_r(DW);
  localparam int N = DW + R;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_valid;
  logic [DW-1:0] enc_data;
  logic          enc_out_valid;
  logic [DW-1:0] enc_out_data;
  logic [R:0]    enc_out_code;
  logic          dec_in_valid;
  logic          dec_in_ready;
  logic [DW-1:0] dec_in_data;
  logic [R:0]    dec_in_code;
  logic          dec_out_valid;
  logic          dec_out_ready;
  logic [DW-1:0] dec_out_data;
  logic          dec_out_sec;
  logic          dec_out_ded;
  logic          cnt_clr;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  ecc_secded_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data),
    .enc_out_valid(enc_out_valid), .enc_out_data(enc_out_data), .enc_out_code(enc_out_code),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
    .dec_in_data(dec_in_data), .dec_in_code(dec_in_code),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .dec_out_data(dec_out_data), .dec_out_sec(dec_out_sec), .dec_out_ded(dec_out_ded),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pow2(int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Reference model: lay the word out as an explicit codeword array indexed by position.
  function automatic logic [R:0] m_enc(input logic [DW-1:0] d);
    logic cw [0:N];
    logic [R:0] c;
    int j = 0;
    for (int pos = 0; pos <= N; pos++) cw[pos] = 1'b0;
    for (int pos = 1; pos <= N; pos++)
      if (!pow2(pos)) begin
        cw[pos] = d[j];
        j++;
      end
    c = '0;
    for (int i = 0; i < R; i++)
      for (int pos = 1; pos <= N; pos++)
        if (((pos >> i) & 1) == 1) c[i] = c[i] ^ cw[pos];
    c[R] = ^d ^ ^c[R-1:0];
    return c;
  endfunction

  task automatic m_dec(input logic [DW-1:0] d, input logic [R:0] c,
                       output logic [DW-1:0] od, output logic sec, output logic ded);
    logic cw [0:N];
    int   dmap [0:N];
    int   j = 0;
    int   k = 0;
    int   syn = 0;
    logic par;
    for (int pos = 0; pos <= N; pos++) begin
      cw[pos] = 1'b0;
      dmap[pos] = 0;
    end
    for (int pos = 1; pos <= N; pos++)
      if (pow2(pos)) begin
        cw[pos] = c[k];
        k++;
      end else begin
        cw[pos] = d[j];
        dmap[pos] = j;
        j++;
      end
    par = c[R];
    for (int pos = 1; pos <= N; pos++)
      if (cw[pos]) begin
        syn = syn ^ pos;
        par = ~par;
      end
    od = d;
    sec = 1'b0;
    ded = 1'b0;
    if (!par) ded = (syn != 0);
    else if (syn > N) ded = 1'b1;
    else begin
      sec = 1'b1;
      if (syn != 0 && !pow2(syn)) od[dmap[syn]] = ~od[dmap[syn]];
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic enc_one(input logic [DW-1:0] d, input string tag);
    enc_valid = 1'b1;
    enc_data  = d;
    tick();
    enc_valid = 1'b0;
    chk({tag, "_ev"}, enc_out_valid, 1);
    chk({tag, "_ed"}, enc_out_data, d);
    chk({tag, "_ec"}, enc_out_code, m_enc(d));
  endtask

  // Single word through an empty pipeline with dec_out_ready high.
  task automatic dec_one(input logic [DW-1:0] d, input logic [R:0] c, input logic [DW-1:0] xd,
                         input logic xs, input logic xe, input string tag);
    dec_in_valid = 1'b1;
    dec_in_data  = d;
    dec_in_code  = c;
    chk({tag, "_rdy"}, dec_in_ready, 1);
    tick();
    dec_in_valid = 1'b0;
    chk({tag, "_lat1"}, dec_out_valid, 0);
    tick();
    chk({tag, "_lat2"}, dec_out_valid, 1);
    chk({tag, "_data"}, dec_out_data, xd);
    chk({tag, "_sec"}, dec_out_sec, xs);
    chk({tag, "_ded"}, dec_out_ded, xe);
  endtask

  logic [DW-1:0] q_d [$];
  logic [R:0]    q_c [$];
  logic [DW-1:0] e_d [$];
  logic          e_s [$];
  logic          e_e [$];

  task automatic stream(input int stall_at, input int stall_len, input bit rnd_ready,
                        input int n_words, output bit saw_block);
    int cyc = 0;
    int got = 0;
    bit holding = 0;
    logic [DW-1:0] hd;
    logic hs, he;
    logic [DW-1:0] od;
    logic os, oe;
    saw_block = 0;
    while (got < n_words && cyc < 400) begin
      if (holding) begin
        chk("hold_valid", dec_out_valid, 1);
        chk("hold_data", dec_out_data, hd);
        chk("hold_flags", {dec_out_sec, dec_out_ded}, {hs, he});
      end
      dec_in_valid = (q_d.size() > 0);
      if (q_d.size() > 0) begin
        dec_in_data = q_d[0];
        dec_in_code = q_c[0];
      end
      dec_out_ready = rnd_ready ? ($urandom_range(3) != 0)
                                : !(cyc >= stall_at && cyc < stall_at + stall_len);
      #3;
      if (dec_in_valid && !dec_in_ready) saw_block = 1;
      if (dec_in_valid && dec_in_ready) begin
        m_dec(q_d[0], q_c[0], od, os, oe);
        e_d.push_back(od);
        e_s.push_back(os);
        e_e.push_back(oe);
        void'(q_d.pop_front());
        void'(q_c.pop_front());
      end
      holding = dec_out_valid && !dec_out_ready;
      hd = dec_out_data;
      hs = dec_out_sec;
      he = dec_out_ded;
      if (dec_out_valid && dec_out_ready) begin
        total++;
        assert (e_d.size() > 0) else begin
          bad++;
          $error("FAIL stream_extra: output %0h with nothing expected", dec_out_data);
        end
        if (e_d.size() > 0) begin
          chk("stream_data", dec_out_data, e_d.pop_front());
          chk("stream_flags", {dec_out_sec, dec_out_ded}, {e_s.pop_front(), e_e.pop_front()});
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    dec_in_valid  = 1'b0;
    dec_out_ready = 1'b1;
    chk("stream_count", got, n_words);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] base;
    logic [DW-1:0] d;
    logic [R:0]    c;
    logic [R:0]    cb;
    bit            blk;
    bit            ghost;
    int            kind;
    int            b1, b2;

    rst = 1'b1; enc_valid = 1'b0; enc_data = '0;
    dec_in_valid = 1'b0; dec_in_data = '0; dec_in_code = '0;
    dec_out_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_enc_valid", enc_out_valid, 0);
    chk("rst_enc_code", enc_out_code, 0);
    chk("rst_out_valid", dec_out_valid, 0);
    chk("rst_in_ready", dec_in_ready, 1);
    chk("rst_out_data", dec_out_data, 0);
    chk("rst_flags", {dec_out_sec, dec_out_ded}, 0);
    chk("rst_cnts", {sec_cnt, ded_cnt}, 0);

    base = 128'hBEC327A2;
    enc_one(base, "enc_base");
    enc_one('0, "enc_zero");
    enc_one('1, "enc_ones");
    tick();
    chk("enc_valid_drop", enc_out_valid, 0);
    for (int i = 0; i < 4; i++) enc_one(rnd_word(), "enc_rnd");

    cb = m_enc(base);
    dec_one(base, cb, 128'hBEC327A2, 0, 0, "rt_base");
    dec_one('0, m_enc('0), '0, 0, 0, "rt_zero");
    dec_one('1, m_enc('1), '1, 0, 0, "rt_ones");
    dec_one(128'hBEC327A3, cb, 128'hBEC327A2, 1, 0, "sec_b0");
    d = base;
    d[127] = ~d[127];
    dec_one(d, cb, 128'hBEC327A2, 1, 0, "sec_b127");
    c = cb;
    c[R] = ~c[R];
    dec_one(base, c, 128'hBEC327A2, 1, 0, "sec_cR");
    c = cb;
    c[3] = ~c[3];
    dec_one(base, c, 128'hBEC327A2, 1, 0, "sec_c3");
    dec_one(128'hBEC32783, cb, 128'hBEC32783, 0, 1, "ded_b0b5");
    c = cb;
    c[2] = ~c[2];
    dec_one(128'hBEC325A2, c, 128'hBEC325A2, 0, 1, "ded_b9c2");
    tick();

    for (int i = 0; i < 8; i++) begin
      d = rnd_word();
      q_d.push_back(d);
      q_c.push_back(m_enc(d));
    end
    stream(3, 3, 0, 8, blk);
    chk("bp_in_ready_dropped", blk, 1);

    for (int i = 0; i < 24; i++) begin
      d = rnd_word();
      c = m_enc(d);
      kind = $urandom_range(3);
      b1 = $urandom_range(DW - 1);
      b2 = (b1 + 1 + $urandom_range(DW - 2)) % DW;
      if (kind == 1) d[b1] = ~d[b1];
      if (kind == 2) c[b1 % (R + 1)] = ~c[b1 % (R + 1)];
      if (kind == 3) begin
        d[b1] = ~d[b1];
        d[b2] = ~d[b2];
      end
      q_d.push_back(d);
      q_c.push_back(c);
    end
    stream(0, 0, 1, 24, blk);

`ifdef ECC_ERR_CNT_EN
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_idle", {sec_cnt, ded_cnt}, 0);
    for (int i = 0; i < 17; i++) begin
      d = rnd_word();
      c = m_enc(d);
      b1 = $urandom_range(DW - 1);
      d[b1] = ~d[b1];
      q_d.push_back(d);
      q_c.push_back(c);
    end
    stream(0, 0, 0, 17, blk);
    chk("cnt_sec_sat", sec_cnt, 15);
    chk("cnt_ded_zero", ded_cnt, 0);
    q_d.push_back(128'hBEC32783);
    q_c.push_back(cb);
    stream(0, 0, 0, 1, blk);
    chk("cnt_ded_one", ded_cnt, 1);
    dec_one(128'hBEC32783, cb, 128'hBEC32783, 0, 1, "cnt_ded_clr");
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_ded_clr_prio", ded_cnt, 0);
    chk("cnt_sec_clr", sec_cnt, 0);
`else
    chk("cnt_off_sec", sec_cnt, 0);
    chk("cnt_off_ded", ded_cnt, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_off_after_clr", {sec_cnt, ded_cnt}, 0);
`endif

    dec_out_ready = 1'b0;
    dec_in_valid  = 1'b1;
    dec_in_data   = 128'h1111;
    dec_in_code   = m_enc(128'h1111);
    tick();
    dec_in_data   = 128'h2222;
    dec_in_code   = m_enc(128'h2222);
    tick();
    dec_in_valid  = 1'b0;
    chk("rst_mid_inflight", dec_out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", dec_out_valid, 0);
    chk("rst_mid_in_ready", dec_in_ready, 1);
    dec_out_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dec_out_valid) ghost = 1;
    end
    chk("rst_mid_no_ghost", ghost, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
